pc_plus4_adder: RTL and testbench
=================================

Name: pc_plus4_adder

Overview:
- Program-counter incrementer for the fetch stage of the pipelined ARMv8 core.
- Produces B + 4 combinationally for next-PC selection.
- Also provides a registered copy with a wrap flag for the IF/ID boundary.
- Built as a generated chain of 4-bit carry-lookahead groups so the incrementer is width-scalable.

Parameters:
- WIDTH, 64, data width of B/Out; must be a multiple of 4, minimum 8.
- INC, 4, increment constant; must be less than 2^WIDTH.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous active-low reset.
- B  input  WIDTH  current PC value.
- en  input  1  load enable for the registered stage; 1 = capture this cycle.
- Out  output  WIDTH  combinational B + INC, modulo 2^WIDTH.
- carry  output  1  combinational carry-out of B + INC (1 = address wrapped).
- Out_q  output  WIDTH  registered Out.
- carry_q  output  1  registered carry.
- valid_q  output  1  set after the first enabled capture following reset.

Behaviour:
- Out = (B + INC) mod 2^WIDTH, purely combinational, zero cycles of latency.
  - Must settle in the same delta as B with no clock involvement.
  - Out is valid even while rst_n = 0.
- carry = bit WIDTH of the (WIDTH+1)-bit sum B + INC.
- Adder structure:
  - WIDTH/4 groups of 4-bit carry-lookahead (generate/propagate per bit, group carry from G/P).
  - Group carries chained; group 0 carry-in = 0.
  - The INC constant is applied as operand A.
  - Must be bit-exact to B + INC.
- Reset (rst_n = 0, asynchronous, takes effect immediately, independent of clk): Out_q = 0, carry_q = 0, valid_q = 0.
- Deassertion of rst_n is sampled on the next rising clk edge; no capture occurs on the edge coincident with release unless rst_n is already high at that edge.
- Rising clk with rst_n = 1 and en = 1: Out_q <= Out, carry_q <= carry, valid_q <= 1.
- Rising clk with en = 0: Out_q, carry_q and valid_q hold their values (stall).
- Wrap: B = 2^WIDTH - INC gives Out = 0, carry = 1.
  - Any B >= 2^WIDTH - INC wraps the same way.
  - carry = 0 for all other B.
- Unknown (X/Z) bits on B propagate to Out; no internal masking.
- No other state; no other handshake.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign (1 bit, combinational) = 1 when B[1:0] != 2'b00, else 0.
  - Adds misalign_q, registered with the same en/reset rules as carry_q; reset value 0.
- When undefined: both ports and their logic are absent.
- Out and carry behaviour are identical either way.

Test Plan:
- Hold rst_n = 0; apply B = 0, 32, 64, 96, 128 at 100 ns intervals -> Out = 4, 36, 68, 100, 132; carry = 0; Out_q = 0, valid_q = 0 throughout.
- Release rst_n, en = 1, B = 0x1000 -> at the next rising edge Out_q = 0x1004, carry_q = 0, valid_q = 1.
- B = 0xFFFF_FFFF_FFFF_FFFC -> Out = 0, carry = 1. B = 0xFFFF_FFFF_FFFF_FFFB -> Out = 0xFFFF_FFFF_FFFF_FFFF, carry = 0.
- Carry chain: B = 0x0000_0000_FFFF_FFFC -> Out = 0x0000_0001_0000_0000. B = 0x0FFF_FFFF_FFFF_FFFC -> Out = 0x1000_0000_0000_0000.
- Stall: capture with B = 0x20, then en = 0 and B = 0x400 for 3 cycles -> Out_q stays 0x24 while Out = 0x404. Assert rst_n = 0 mid-cycle -> Out_q = 0, valid_q = 0 immediately.
- With PC_ALIGN_CHECK_EN: B = 0x102 -> misalign = 1, Out = 0x106. B = 0x104 -> misalign = 0. Without the macro, the build has no misalign port.

Source files
------------

// File: rtl/pc_plus4_adder.sv
// PC incrementer: B + INC via chained 4-bit CLA groups, plus IF/ID register.
// Optional PC_ALIGN_CHECK_EN adds misalign / misalign_q outputs.
module pc_plus4_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned INC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  output logic [WIDTH-1:0] Out,
  output logic             carry,
  output logic [WIDTH-1:0] Out_q,
  output logic             carry_q,
  output logic             valid_q
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misalign,
  output logic             misalign_q
`endif
);

  localparam int unsigned NG = WIDTH / 4;
  localparam logic [WIDTH-1:0] A = WIDTH'(INC);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 8");
  end

  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum;

  assign gc[0] = 1'b0;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       pp;
    logic       ci;

    assign ci = gc[k];
    assign g  = A[4*k +: 4] & B[4*k +: 4];
    assign p  = A[4*k +: 4] ^ B[4*k +: 4];

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0])
                | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & ci);

    // Group generate/propagate feed the next group's carry-in
    assign gg = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
    assign pp = &p;

    assign gc[k+1]      = gg | (pp & ci);
    assign sum[4*k +: 4] = p ^ c;
  end

  assign Out   = sum;
  assign carry = gc[NG];

  logic [WIDTH-1:0] Out_d;
  logic             carry_d;
  logic             valid_d;

  always_comb begin
    Out_d   = Out_q;
    carry_d = carry_q;
    valid_d = valid_q;
    if (en) begin
      Out_d   = Out;
      carry_d = carry;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      Out_q   <= Out_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_d;

  assign misalign = |B[1:0];

  always_comb begin
    misalign_d = misalign_q;
    if (en) misalign_d = misalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

endmodule

// File: tb/tb_pc_plus4_adder.sv
// Scoreboard bench for pc_plus4_adder (WIDTH=64, INC=4).
// Expected values come from a plain 65-bit add model.
module tb_pc_plus4_adder;

  logic        clk;
  logic        rst_n;
  logic [63:0] B;
  logic        en;
  logic [63:0] Out;
  logic        carry;
  logic [63:0] Out_q;
  logic        carry_q;
  logic        valid_q;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
  logic        misalign_q;
`endif

  pc_plus4_adder #(.WIDTH(64), .INC(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .B       (B),
    .en      (en),
    .Out     (Out),
    .carry   (carry),
    .Out_q   (Out_q),
    .carry_q (carry_q),
    .valid_q (valid_q)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign   (misalign),
    .misalign_q (misalign_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] out;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q_comb[$];
  exp_t q_reg[$];

  int n_chk;
  int n_pass;

  exp_t reg_m;

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic exp_t model(logic [63:0] b);
    logic [64:0] s;
    exp_t e;
    s     = {1'b0, b} + 65'd4;
    e.out = s[63:0];
    e.c   = s[64];
    e.v   = 1'b1;
    return e;
  endfunction

  task automatic pop_comb(string tag);
    exp_t e;
    if (q_comb.size() == 0) begin
      chk({tag, "_empty"}, 64'd0, 64'd1);
      return;
    end
    e = q_comb.pop_front();
    chk({tag, "_out"}, Out, e.out);
    chk({tag, "_c"}, {63'd0, carry}, {63'd0, e.c});
  endtask

  task automatic pop_reg(string tag);
    exp_t e;
    if (q_reg.size() == 0) begin
      chk({tag, "_empty"}, 64'd0, 64'd1);
      return;
    end
    e = q_reg.pop_front();
    chk({tag, "_outq"}, Out_q, e.out);
    chk({tag, "_cq"}, {63'd0, carry_q}, {63'd0, e.c});
    chk({tag, "_vq"}, {63'd0, valid_q}, {63'd0, e.v});
  endtask

  // Drive at negedge, check comb at +1, check reg after posedge
  task automatic drive(string tag, logic [63:0] b, logic e);
    @(negedge clk);
    B  = b;
    en = e;
    q_comb.push_back(model(b));
    if (e) reg_m = model(b);
    q_reg.push_back(reg_m);
    #1;
    pop_comb(tag);
    @(posedge clk);
    #1;
    pop_reg(tag);
  endtask

  logic [63:0] vec [5];

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    en     = 1'b1;
    B      = '0;
    reg_m.out = '0;
    reg_m.c   = 1'b0;
    reg_m.v   = 1'b0;

    for (int i = 0; i < 5; i++) begin
      B = 64'(i * 32);
      q_comb.push_back(model(B));
      #1;
      pop_comb("rst_comb");
      q_reg.push_back(reg_m);
      pop_reg("rst_reg");
      #99;
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive("first", 64'h1000, 1'b1);
    chk("first_lit", Out_q, 64'h1004);

    vec[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    vec[1] = 64'hFFFF_FFFF_FFFF_FFFB;
    vec[2] = 64'h0000_0000_FFFF_FFFC;
    vec[3] = 64'h0FFF_FFFF_FFFF_FFFC;
    vec[4] = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 5; i++)
      drive($sformatf("vec%0d", i), vec[i], 1'b1);

    for (int i = 0; i < 20; i++)
      drive("rnd", {$urandom, $urandom}, 1'b1);

    drive("cap", 64'h20, 1'b1);
    for (int i = 0; i < 3; i++)
      drive("stall", 64'h400, 1'b0);
    chk("stall_outq", Out_q, 64'h24);
    chk("stall_out", Out, 64'h404);

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outq", Out_q, 64'd0);
    chk("arst_vq", {63'd0, valid_q}, 64'd0);
    chk("arst_cq", {63'd0, carry_q}, 64'd0);
    chk("arst_out", Out, 64'h404);
    reg_m.out = '0;
    reg_m.c   = 1'b0;
    reg_m.v   = 1'b0;

    @(posedge clk);
    #1;
    chk("hold_vq", {63'd0, valid_q}, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive("relwrap", 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);

`ifdef PC_ALIGN_CHECK_EN
    drive("mis1", 64'h102, 1'b1);
    chk("mis1_lit", Out_q, 64'h106);
    chk("mis1_mq", {63'd0, misalign_q}, 64'd1);
    @(negedge clk);
    B = 64'h104;
    #1;
    chk("mis0", {63'd0, misalign}, 64'd0);
    B = 64'h102;
    #1;
    chk("mis1c", {63'd0, misalign}, 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
